display_scanout: RTL and testbench
==================================

Name: display_scanout

Overview:
Reader side of the pixel framebuffer that the GPU extension writes. Generates raster timing, reads one 16-bit framebuffer word per active pixel through a synchronous read port, and drives RGB555 video with hsync/vsync/de. It sits between framebuffer memory and the display PHY/simulation sink.

Parameters:
H_ACTIVE, 160, visible pixels per line
H_FP, 8, horizontal front porch cycles
H_SYNC, 16, hsync pulse cycles
H_BP, 16, horizontal back porch cycles
V_ACTIVE, 120, visible lines per frame
V_FP, 2, vertical front porch lines
V_SYNC, 2, vsync pulse lines
V_BP, 6, vertical back porch lines
FB_BASE, 24'h000000, framebuffer word address of pixel (0,0)

Ports:
clk  in  1  pixel/system clock
r  in  1  asynchronous active-low reset
en  in  1  scan enable, sampled at frame boundary
fb_addr  out  24  framebuffer read word address
fb_re  out  1  read strobe; data returned next cycle
fb_data  in  16  read data, valid 1 cycle after fb_re; [14:0] RGB555, [15] ignored
hsync  out  1  horizontal sync, active-low
vsync  out  1  vertical sync, active-low
de  out  1  display enable (active pixel)
red  out  5  fb_data[14:10]
green  out  5  fb_data[9:5]
blue  out  5  fb_data[4:0]
frame_start  out  1  one-cycle pulse coincident with output pixel (0,0)

Behaviour:
- One clock, one asynchronous active-low reset. Reset is clk and r, active-low (r=0 resets).
- Reset values: hsync=1, vsync=1, de=0, red/green/blue=0, fb_re=0, fb_addr=FB_BASE, frame_start=0; state IDLE; h_cnt=v_cnt=0; pipeline valids cleared.
- Reset mid-frame aborts immediately; after release the block re-enters IDLE.
- H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Line order: active, front porch, sync, back porch.
- States: IDLE (counters held at 0, no reads, syncs inactive, de=0) -> SCAN when en=1 (first scan cycle is the one after en is sampled high). SCAN -> IDLE only at the last cycle of a frame (h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1) with en=0. Deasserting en mid-frame has no effect until the frame completes.
- Stage 0 (counters): h_cnt wraps H_TOTAL-1->0 and increments v_cnt; v_cnt wraps V_TOTAL-1->0. active0 = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE. fb_re=active0 (combinational from registered counters). fb_addr is a register: FB_BASE at (0,0), +1 after every active read, no multiply; not advanced during blanking.
- Stage 1: fb_data captured when the stage-0 read valid is delayed by one.
- Stage 2 (registered outputs): de, RGB, hsync, vsync, frame_start all delayed 2 cycles from stage 0 so they align. RGB forced to 0 when de=0. hsync low when h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; vsync low when v_cnt in the equivalent range (entire line).
- Total latency from counter (x,y) to output: 2 cycles. The pipeline drains normally after SCAN->IDLE; outputs reach reset values 2 cycles after entering IDLE.
- fb_addr is 24-bit and wraps modulo 2^24 without error.

Decomposition:
- Package display_pkg: rgb555_t packed struct (r[4:0], g[4:0], b[4:0]), field bit-position constants, FB_PIXEL_RESET_BIT=15, timing localparam helpers (H_TOTAL/V_TOTAL functions).
- Sub-module scan_timing: h/v counters, IDLE/SCAN FSM, active/sync stage-0 flags. The top contains the address generator, read pipeline, and output registers.

Test Plan:
- Reset: H_ACTIVE=4,H_FP=1,H_SYNC=2,H_BP=1,V_ACTIVE=3,V_FP=1,V_SYNC=1,V_BP=1, r=0 with en=1 -> hsync=vsync=1, de=0, RGB=0, fb_re=0, fb_addr=0; no reads until r=1.
- Full frame: model returns fb_data=addr|16'h8000 -> exactly 12 fb_re pulses at addresses 0..11. Output RGB equals addr[14:0] split, bit15 ignored. Frame length is 48 cycles; de high 4 cycles per line for 3 lines.
- Sync timing: hsync low on output-aligned h=5..6 of each line; vsync low for all 8 cycles of line 4; frame_start pulses once, 2 cycles after stage-0 (0,0).
- Enable at boundary: drop en at mid-frame -> the frame completes, then IDLE with zero reads. Raise en again -> a new frame starts with fb_addr=FB_BASE.
- Async reset mid-line: assert r=0 at h=2,v=1 -> outputs return to reset values without waiting for clk. After release and en=1, scanning restarts from (0,0).
- FB_BASE=24'hFFFFFE -> reads 0xFFFFFE, 0xFFFFFF, 0x000000, ... wraps cleanly.

Source files
------------

// File: rtl/display_scanout_pkg.sv
// Shared types and helpers for the framebuffer scanout block: pixel word
// layout and raster timing arithmetic.
package display_pkg;

  localparam int FB_ADDR_W          = 24;
  localparam int FB_DATA_W          = 16;
  localparam int FB_PIXEL_RESET_BIT = 15;

  localparam int RGB_R_LSB = 10;
  localparam int RGB_G_LSB = 5;
  localparam int RGB_B_LSB = 0;
  localparam int RGB_CH_W  = 5;

  typedef struct packed {
    logic [RGB_CH_W-1:0] r;
    logic [RGB_CH_W-1:0] g;
    logic [RGB_CH_W-1:0] b;
  } rgb555_t;

  function automatic int h_total(int active, int fp, int sync, int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int v_total(int active, int fp, int sync, int bp);
    return active + fp + sync + bp;
  endfunction

  // Bit 15 of a framebuffer word carries no colour and is dropped here.
  function automatic rgb555_t to_rgb555(logic [FB_DATA_W-1:0] word);
    return rgb555_t'(15'(word));
  endfunction

endpackage

// File: rtl/display_scanout_if.sv
// Synchronous framebuffer read port: address/strobe out, data back one
// cycle after the strobe.
interface display_scanout_if;
  import display_pkg::*;

  logic [FB_ADDR_W-1:0] fb_addr;
  logic                 fb_re;
  logic [FB_DATA_W-1:0] fb_data;

  modport master (output fb_addr, output fb_re, input fb_data);
  modport slave  (input fb_addr, input fb_re, output fb_data);

endinterface

// File: rtl/display_scanout_scan_timing.sv
// Raster counters and IDLE/SCAN sequencing; produces the stage-0 flags
// that the scanout pipeline delays into video timing.
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   IDLE    | counters held at (0,0), no reads, syncs inactive
//   SCAN    | counters free-running; leaves only at last cycle of frame
module scan_timing
  import display_pkg::*;
#(
  parameter int H_ACTIVE = 160,
  parameter int H_FP     = 8,
  parameter int H_SYNC   = 16,
  parameter int H_BP     = 16,
  parameter int V_ACTIVE = 120,
  parameter int V_FP     = 2,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 6
) (
  input  logic clk,
  input  logic r,
  input  logic en,
  output logic scan_o,
  output logic active0_o,
  output logic hs0_o,
  output logic vs0_o,
  output logic first0_o,
  output logic frame_last_o
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_C   = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT_C   = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_FIRST  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_LAST   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] VS_FIRST  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_LAST   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;

  always_comb begin
    state_d = state_q;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    case (state_q)
      ST_IDLE: begin
        h_cnt_d = '0;
        v_cnt_d = '0;
        if (en) state_d = ST_SCAN;
      end
      default: begin
        if (h_cnt_q == H_LAST) begin
          h_cnt_d = '0;
          if (v_cnt_q == V_LAST) begin
            v_cnt_d = '0;
            // en is only honoured here so a frame is never cut short.
            if (!en) state_d = ST_IDLE;
          end else begin
            v_cnt_d = v_cnt_q + VW'(1);
          end
        end else begin
          h_cnt_d = h_cnt_q + HW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      state_q <= ST_IDLE;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign scan_o       = (state_q == ST_SCAN);
  assign active0_o    = scan_o && (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
  assign hs0_o        = scan_o && (h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST);
  assign vs0_o        = scan_o && (v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST);
  assign first0_o     = scan_o && (h_cnt_q == '0) && (v_cnt_q == '0);
  assign frame_last_o = scan_o && (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);

endmodule

// File: rtl/display_scanout.sv
// Framebuffer scanout: sequential address generation, synchronous read,
// and a two-stage pipeline that aligns RGB555 with sync/de timing.
module display_scanout
  import display_pkg::*;
#(
  parameter int                   H_ACTIVE = 160,
  parameter int                   H_FP     = 8,
  parameter int                   H_SYNC   = 16,
  parameter int                   H_BP     = 16,
  parameter int                   V_ACTIVE = 120,
  parameter int                   V_FP     = 2,
  parameter int                   V_SYNC   = 2,
  parameter int                   V_BP     = 6,
  parameter logic [FB_ADDR_W-1:0] FB_BASE  = 24'h000000
) (
  input  logic                 clk,
  input  logic                 r,
  input  logic                 en,
  display_scanout_if.master    fb,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 de,
  output logic [RGB_CH_W-1:0]  red,
  output logic [RGB_CH_W-1:0]  green,
  output logic [RGB_CH_W-1:0]  blue,
  output logic                 frame_start
);

  logic scan, active0, hs0, vs0, first0, frame_last;

  scan_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk          (clk),
    .r            (r),
    .en           (en),
    .scan_o       (scan),
    .active0_o    (active0),
    .hs0_o        (hs0),
    .vs0_o        (vs0),
    .first0_o     (first0),
    .frame_last_o (frame_last)
  );

  logic [FB_ADDR_W-1:0] addr_q, addr_d;

  // Reload at the frame's last cycle so every frame starts at FB_BASE.
  always_comb begin
    addr_d = addr_q;
    if (!scan || frame_last) addr_d = FB_BASE;
    else if (active0)        addr_d = addr_q + 24'd1;
  end

  always_ff @(posedge clk or negedge r) begin
    if (!r) addr_q <= FB_BASE;
    else    addr_q <= addr_d;
  end

  assign fb.fb_addr = addr_q;
  assign fb.fb_re   = active0;

  logic valid1_q, hs1_q, vs1_q, first1_q;

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      valid1_q <= 1'b0;
      hs1_q    <= 1'b0;
      vs1_q    <= 1'b0;
      first1_q <= 1'b0;
    end else begin
      valid1_q <= active0;
      hs1_q    <= hs0;
      vs1_q    <= vs0;
      first1_q <= first0;
    end
  end

  rgb555_t rgb_q, rgb_d;
  logic    de_q, hsync_q, vsync_q, fs_q;

  assign rgb_d = valid1_q ? to_rgb555(fb.fb_data) : '0;

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      rgb_q   <= '0;
      de_q    <= 1'b0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      fs_q    <= 1'b0;
    end else begin
      rgb_q   <= rgb_d;
      de_q    <= valid1_q;
      hsync_q <= ~hs1_q;
      vsync_q <= ~vs1_q;
      fs_q    <= first1_q;
    end
  end

  assign red         = rgb_q.r;
  assign green       = rgb_q.g;
  assign blue        = rgb_q.b;
  assign de          = de_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_display_scanout.sv
// Directed bench for display_scanout on an 8x6 raster (4x3 visible), with a
// second instance whose base address sits just below the 24-bit wrap.
module tb_display_scanout;

  logic clk;
  logic r_a, en_a, r_b, en_b;
  logic hsync_a, vsync_a, de_a, fs_a;
  logic [4:0] red_a, green_a, blue_a;
  logic hsync_b, vsync_b, de_b, fs_b;
  logic [4:0] red_b, green_b, blue_b;

  int nchecks = 0;
  int nerr    = 0;
  int reads_a = 0;
  int fs_cnt  = 0;

  display_scanout_if bus_a ();
  display_scanout_if bus_b ();

  display_scanout #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .FB_BASE(24'h000000)
  ) dut_a (
    .clk(clk), .r(r_a), .en(en_a), .fb(bus_a),
    .hsync(hsync_a), .vsync(vsync_a), .de(de_a),
    .red(red_a), .green(green_a), .blue(blue_a), .frame_start(fs_a)
  );

  display_scanout #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .FB_BASE(24'hFFFFFE)
  ) dut_b (
    .clk(clk), .r(r_b), .en(en_b), .fb(bus_b),
    .hsync(hsync_b), .vsync(vsync_b), .de(de_b),
    .red(red_b), .green(green_b), .blue(blue_b), .frame_start(fs_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: word = address | 0x8000; blanking returns junk that must not leak.
  always @(posedge clk) begin
    bus_a.fb_data <= bus_a.fb_re ? (bus_a.fb_addr[15:0] | 16'h8000) : 16'h5A5A;
    bus_b.fb_data <= bus_b.fb_re ? (bus_b.fb_addr[15:0] | 16'h8000) : 16'h5A5A;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // s0/so: frame-relative stage-0 and output indices, -1 when idle/drained.
  task automatic check_a(input int s0, input int so);
    int h, v, oh, ov;
    logic re, d;
    if (s0 >= 0) begin
      h  = (s0 % 48) % 8;
      v  = (s0 % 48) / 8;
      re = (h < 4) && (v < 3);
      chk("a_fb_re", 32'(bus_a.fb_re), 32'(re));
      if (re) chk("a_fb_addr", 32'(bus_a.fb_addr), 32'(v * 4 + h));
    end else begin
      chk("a_fb_re_idle", 32'(bus_a.fb_re), 32'd0);
      chk("a_fb_addr_idle", 32'(bus_a.fb_addr), 32'd0);
    end
    if (so >= 0) begin
      oh = (so % 48) % 8;
      ov = (so % 48) / 8;
      d  = (oh < 4) && (ov < 3);
      chk("a_de", 32'(de_a), 32'(d));
      chk("a_red", 32'(red_a), 32'd0);
      chk("a_green", 32'(green_a), 32'd0);
      chk("a_blue", 32'(blue_a), d ? 32'(ov * 4 + oh) : 32'd0);
      chk("a_hsync", 32'(hsync_a), (oh == 5 || oh == 6) ? 32'd0 : 32'd1);
      chk("a_vsync", 32'(vsync_a), (ov == 4) ? 32'd0 : 32'd1);
      chk("a_frame_start", 32'(fs_a), (oh == 0 && ov == 0) ? 32'd1 : 32'd0);
    end else begin
      chk("a_de_rst", 32'(de_a), 32'd0);
      chk("a_rgb_rst", 32'({red_a, green_a, blue_a}), 32'd0);
      chk("a_hsync_rst", 32'(hsync_a), 32'd1);
      chk("a_vsync_rst", 32'(vsync_a), 32'd1);
      chk("a_fs_rst", 32'(fs_a), 32'd0);
    end
  endtask

  task automatic check_b(input int s0, input int so);
    int h, v;
    logic [23:0] a;
    h = s0 % 8;
    v = s0 / 8;
    if (h < 4 && v < 3) begin
      a = 24'hFFFFFE + 24'(v * 4 + h);
      chk("b_fb_re", 32'(bus_b.fb_re), 32'd1);
      chk("b_fb_addr", 32'(bus_b.fb_addr), 32'(a));
    end else begin
      chk("b_fb_re_blank", 32'(bus_b.fb_re), 32'd0);
    end
    if (so >= 0) begin
      h = so % 8;
      v = so / 8;
      a = 24'hFFFFFE + 24'(v * 4 + h);
      if (h < 4 && v < 3) begin
        chk("b_de", 32'(de_b), 32'd1);
        chk("b_rgb", 32'({red_b, green_b, blue_b}), 32'(a[14:0]));
      end else begin
        chk("b_de_blank", 32'(de_b), 32'd0);
        chk("b_rgb_blank", 32'({red_b, green_b, blue_b}), 32'd0);
      end
    end
  endtask

  initial begin
    r_a = 1'b0; en_a = 1'b1;
    r_b = 1'b0; en_b = 1'b1;

    // Held in reset with en high: no reads, idle outputs.
    repeat (3) begin
      @(negedge clk);
      check_a(-1, -1);
    end
    r_a = 1'b1;
    @(posedge clk);

    // Two frames; en dropped mid-frame two, then idle drain.
    for (int i = 0; i < 110; i++) begin
      @(negedge clk);
      check_a((i < 96) ? i : -1, (i >= 2 && i < 98) ? i - 2 : -1);
      if (i < 48 && bus_a.fb_re) reads_a++;
      if (i >= 2 && i < 50 && fs_a) fs_cnt++;
      if (i == 60) en_a = 1'b0;
    end
    chk("a_reads_per_frame", 32'(reads_a), 32'd12);
    chk("a_frame_start_count", 32'(fs_cnt), 32'd1);

    // Re-enable; abort with async reset at (h=2, v=1).
    en_a = 1'b1;
    for (int j = 0; j <= 10; j++) begin
      @(negedge clk);
      check_a(j, (j >= 2) ? j - 2 : -1);
    end
    r_a = 1'b0;
    #1;
    check_a(-1, -1);
    @(negedge clk);
    @(negedge clk);
    r_a = 1'b1;
    for (int j = 0; j < 14; j++) begin
      @(negedge clk);
      check_a(j, (j >= 2) ? j - 2 : -1);
    end

    // Base address at top of the 24-bit space wraps through zero.
    @(negedge clk);
    r_b = 1'b1;
    for (int j = 0; j < 14; j++) begin
      @(negedge clk);
      check_b(j, (j >= 2) ? j - 2 : -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
